// File: rtl/map_ss_seq.sv
`default_nettype none
// ============================================================================
// Module   : map_ss_seq
// Function : Save-state sequencer. Walks the mapper's save-state registers and
//            copies them to a snapshot buffer (save) or back into the mapper
//            (load). Define SS_SUM_EN to add the ss_sum byte checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module map_ss_seq #(
   parameter int SS_LEN  = 128,
   parameter int SETTLE  = 2,
   parameter int WE_HOLD = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_save,
   input  logic       start_load,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       ss_act,
   output logic       ss_we,
   output logic [7:0] ss_addr,
   output logic [7:0] ss_wdat,
   input  logic [7:0] ss_rdat,
   output logic       mem_req,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdat,
   input  logic [7:0] mem_rdat,
   input  logic       mem_ack
`ifdef SS_SUM_EN
   ,
   output logic [7:0] ss_sum
`endif
);

   localparam int                c_cnt_max    = (WE_HOLD > SETTLE) ? WE_HOLD : SETTLE;
   localparam int                c_cw         = $clog2(c_cnt_max + 1);
   localparam logic [c_cw-1:0]   c_settle_end = c_cw'(SETTLE - 1);
   localparam logic [c_cw-1:0]   c_hold_end   = c_cw'(WE_HOLD - 1);
   localparam logic [7:0]        c_last_addr  = 8'(SS_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_SMEM   = 3'd2,
      S_LMEM   = 3'd3,
      S_LWE    = 3'd4,
      S_NEXT   = 3'd5,
      S_FIN    = 3'd6
   } state_t;

   state_t            r_state;
   logic [c_cw-1:0]   r_cnt;
   logic [7:0]        r_addr;
   logic              r_is_save;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_act;
   logic              r_we;
   logic [7:0]        r_wdat;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [7:0]        r_mem_wdat;
`ifdef SS_SUM_EN
   logic [7:0]        r_sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_addr     <= 8'd0;
         r_is_save  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_act      <= 1'b0;
         r_we       <= 1'b0;
         r_wdat     <= 8'd0;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_wdat <= 8'd0;
`ifdef SS_SUM_EN
         r_sum      <= 8'd0;
`endif
      end else begin
         r_done <= 1'b0;
         // Abort outranks everything, including an ack landing in the same cycle.
         if (r_state != S_IDLE && abort) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_mem_req <= 1'b0;
            r_act     <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start_save || start_load) begin
                     r_addr    <= 8'd0;
                     r_busy    <= 1'b1;
                     r_err     <= 1'b0;
                     r_act     <= 1'b1;
                     r_is_save <= start_save;
                     r_cnt     <= '0;
                     r_state   <= S_SETTLE;
`ifdef SS_SUM_EN
                     r_sum     <= 8'd0;
`endif
                  end
               end
               S_SETTLE: begin
                  if (r_cnt == c_settle_end) begin
                     r_mem_req <= 1'b1;
                     r_mem_we  <= r_is_save;
                     if (r_is_save) begin
                        r_mem_wdat <= ss_rdat;
                        r_state    <= S_SMEM;
                     end else begin
                        r_state    <= S_LMEM;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_SMEM: begin
                  if (mem_ack) begin
                     r_mem_req <= 1'b0;
                     r_state   <= S_NEXT;
`ifdef SS_SUM_EN
                     r_sum     <= r_sum + r_mem_wdat;
`endif
                  end
               end
               S_LMEM: begin
                  if (mem_ack) begin
                     r_mem_req <= 1'b0;
                     r_wdat    <= mem_rdat;
                     r_we      <= 1'b1;
                     r_cnt     <= '0;
                     r_state   <= S_LWE;
`ifdef SS_SUM_EN
                     r_sum     <= r_sum + mem_rdat;
`endif
                  end
               end
               S_LWE: begin
                  if (r_cnt == c_hold_end) begin
                     r_we    <= 1'b0;
                     r_state <= S_NEXT;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_NEXT: begin
                  r_cnt <= '0;
                  // Compare before incrementing so SS_LEN=256 ends at 255 without wrapping.
                  if (r_addr == c_last_addr) begin
                     r_state <= S_FIN;
                  end else begin
                     r_addr  <= r_addr + 8'd1;
                     r_state <= S_SETTLE;
                  end
               end
               S_FIN: begin
                  r_done  <= 1'b1;
                  r_act   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;
   assign ss_act   = r_act;
   assign ss_we    = r_we;
   assign ss_addr  = r_addr;
   assign ss_wdat  = r_wdat;
   assign mem_req  = r_mem_req;
   assign mem_we   = r_mem_we;
   assign mem_addr = r_addr;
   assign mem_wdat = r_mem_wdat;
`ifdef SS_SUM_EN
   assign ss_sum   = r_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_map_ss_seq.sv
`default_nettype none
// Bench for map_ss_seq: randomized save/load transfers against a slow-mapper and
// variable-latency buffer model, plus abort, reset and SS_LEN=256 boundary cases.
module tb_map_ss_seq;
   localparam int SS_LEN  = 128;
   localparam int SETTLE  = 2;
   localparam int WE_HOLD = 24;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start_save = 1'b0, start_load = 1'b0, abort = 1'b0;
   logic       busy, done, err, ss_act, ss_we, mem_req, mem_we;
   logic [7:0] ss_addr, ss_wdat, mem_addr, mem_wdat;
   logic [7:0] ss_rdat = 8'd0, mem_rdat = 8'd0;
   logic       mem_ack = 1'b0;

   logic       b_start = 1'b0, b_zero = 1'b0;
   logic       b_busy, b_done, b_err, b_act, b_we, b_mreq, b_mwe;
   logic [7:0] b_addr, b_wdat, b_maddr, b_mwdat;
   logic [7:0] b_rdat = 8'd0, b_mrdat = 8'd0;
   logic       b_ack = 1'b0;
`ifdef SS_SUM_EN
   logic [7:0] ss_sum, b_sum;
`endif

   always #5 clk = ~clk;

   map_ss_seq #(.SS_LEN(SS_LEN), .SETTLE(SETTLE), .WE_HOLD(WE_HOLD)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_save(start_save), .start_load(start_load),
      .abort(abort), .busy(busy), .done(done), .err(err), .ss_act(ss_act),
      .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
      .mem_rdat(mem_rdat), .mem_ack(mem_ack)
`ifdef SS_SUM_EN
      , .ss_sum(ss_sum)
`endif
   );

   map_ss_seq #(.SS_LEN(256), .SETTLE(1), .WE_HOLD(4)) u_dut256 (
      .clk(clk), .rst_n(rst_n), .start_save(b_start), .start_load(b_zero),
      .abort(b_zero), .busy(b_busy), .done(b_done), .err(b_err), .ss_act(b_act),
      .ss_we(b_we), .ss_addr(b_addr), .ss_wdat(b_wdat), .ss_rdat(b_rdat),
      .mem_req(b_mreq), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdat(b_mwdat),
      .mem_rdat(b_mrdat), .mem_ack(b_ack)
`ifdef SS_SUM_EN
      , .ss_sum(b_sum)
`endif
   );

   logic [7:0] map_reg [256];
   logic [7:0] buf_mem [256];
   logic [7:0] b_buf   [256];
   int mem_lat = 1;
   int n_chk = 0, n_err = 0;
   int done_cnt, we_pulses, we_len_bad, we_unstable, req_len_bad, addr_move_bad, addr_mirror_bad;
   int b_wrap = 0, b_max = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Mapper + buffer environment, evaluated 1 time unit after each rising edge.
   initial begin : env
      logic [7:0] p_addr, p_dat, prev_addr;
      logic       prev_we, prev_req;
      int         stable, rq, plen;
      p_addr = 0; p_dat = 0; prev_addr = 0; prev_we = 0; prev_req = 0;
      stable = 0; rq = 0; plen = 0;
      forever begin
         @(posedge clk); #1;
         // Mapper readback is only valid once the address has been stable for SETTLE cycles.
         if (ss_addr != prev_addr) stable = 0; else stable++;
         ss_rdat = (stable >= SETTLE - 1) ? map_reg[ss_addr] : 8'($urandom);
         if (ss_addr != prev_addr && (prev_req || prev_we || mem_req || ss_we)) addr_move_bad++;
         if (mem_addr !== ss_addr) addr_mirror_bad++;
         if (done) done_cnt++;
         if (ss_we) begin
            if (!prev_we) begin
               plen = 1; p_addr = ss_addr; p_dat = ss_wdat;
            end else begin
               plen++;
               if (ss_addr != p_addr || ss_wdat != p_dat) we_unstable++;
            end
         end else if (prev_we) begin
            map_reg[p_addr] = p_dat;
            we_pulses++;
            if (plen != WE_HOLD) we_len_bad++;
         end
         mem_ack  = 1'b0;
         mem_rdat = 8'($urandom);
         if (mem_req) begin
            rq++;
            if (rq == mem_lat + 1) begin
               mem_ack = 1'b1;
               if (mem_we) buf_mem[mem_addr] = mem_wdat;
               else        mem_rdat = buf_mem[mem_addr];
            end
         end else begin
            if (rq != 0 && rq != mem_lat + 1) req_len_bad++;
            rq = 0;
            if ($urandom_range(0, 3) == 0) mem_ack = 1'b1;
         end
         prev_addr = ss_addr; prev_req = mem_req; prev_we = ss_we;
      end
   end

   initial begin : env_b
      logic [7:0] prev;
      int rq;
      prev = 0; rq = 0;
      forever begin
         @(posedge clk); #1;
         b_rdat = b_addr ^ 8'hC3;
         b_ack  = 1'b0;
         if (b_mreq) begin
            rq++;
            if (rq == 2) begin
               b_ack = 1'b1;
               if (b_mwe) b_buf[b_maddr] = b_mwdat;
            end
         end else begin
            rq = 0;
         end
         if (b_busy && b_addr < prev) b_wrap++;
         if (int'(b_addr) > b_max) b_max = int'(b_addr);
         prev = b_addr;
      end
   end

   task automatic clr_counters();
      done_cnt = 0; we_pulses = 0; we_len_bad = 0; we_unstable = 0;
      req_len_bad = 0; addr_move_bad = 0; addr_mirror_bad = 0;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_busy"}, busy, 0);       chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);         chk({tag, "_ss_act"}, ss_act, 0);
      chk({tag, "_ss_we"}, ss_we, 0);     chk({tag, "_ss_addr"}, ss_addr, 0);
      chk({tag, "_ss_wdat"}, ss_wdat, 0); chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_mem_we"}, mem_we, 0);   chk({tag, "_mem_wdat"}, mem_wdat, 0);
   endtask

   task automatic start_pulse(input bit sv, input bit ld);
      @(posedge clk); #1;
      start_save = sv; start_load = ld;
      @(posedge clk); #1;
      start_save = 1'b0; start_load = 1'b0;
   endtask

   task automatic run_xfer(input string tag, input bit save, input bit both, input int lat);
      logic [7:0] exp_buf [256];
      logic [7:0] exp_map [256];
      logic [7:0] exp_sum;
      int cyc, exp_cyc, bad;
      bit to;
      exp_buf = buf_mem; exp_map = map_reg; exp_sum = 8'd0;
      for (int a = 0; a < SS_LEN; a++) begin
         if (save) exp_buf[a] = map_reg[a]; else exp_map[a] = buf_mem[a];
         exp_sum = 8'(exp_sum + (save ? map_reg[a] : buf_mem[a]));
      end
      exp_cyc = SS_LEN * (SETTLE + 2 + lat + (save ? 0 : WE_HOLD)) + 2;
      mem_lat = lat;
      clr_counters();
      start_pulse(save || both, !save || both);
      cyc = 1; to = 0;
      chk({tag, "_busy_rise"}, busy, 1);
      chk({tag, "_act_rise"}, ss_act, 1);
      chk({tag, "_err_clr"}, err, 0);
      while (!done) begin
         // A start pulse while busy must be ignored.
         start_save = (cyc == 50); start_load = (cyc == 50);
         @(posedge clk); #1;
         cyc++;
         if (cyc > exp_cyc + 2000) begin to = 1; break; end
      end
      start_save = 1'b0; start_load = 1'b0;
      chk({tag, "_timeout"}, to, 0);
      chk({tag, "_cycles"}, cyc, exp_cyc);
      @(posedge clk); #1;
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_done_low"}, done, 0);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_act_end"}, ss_act, 0);
      chk({tag, "_we_pulses"}, we_pulses, save ? 0 : SS_LEN);
      chk({tag, "_we_len_bad"}, we_len_bad, 0);
      chk({tag, "_we_unstable"}, we_unstable, 0);
      chk({tag, "_req_len_bad"}, req_len_bad, 0);
      chk({tag, "_addr_move_bad"}, addr_move_bad, 0);
      chk({tag, "_addr_mirror_bad"}, addr_mirror_bad, 0);
      bad = 0;
      for (int a = 0; a < 256; a++) begin
         if (buf_mem[a] !== exp_buf[a]) bad++;
         if (map_reg[a] !== exp_map[a]) bad++;
      end
      chk({tag, "_data_bad"}, bad, 0);
`ifdef SS_SUM_EN
      chk({tag, "_sum"}, ss_sum, exp_sum);
`endif
   endtask

   task automatic wait_for(input string tag, input logic [7:0] addr, input bit on_we);
      bit to;
      to = 1;
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk); #1;
         if (ss_addr == addr && (on_we ? ss_we : mem_req)) begin to = 0; break; end
      end
      chk({tag, "_reach_timeout"}, to, 0);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   initial begin : main
      int cyc, bad;
      bit to;
      for (int a = 0; a < 256; a++) begin
         map_reg[a] = 8'(a) ^ 8'h5A;
         buf_mem[a] = 8'($urandom);
         b_buf[a]   = 8'd0;
      end
      #2 rst_n = 1'b0;
      #1 chk_rst("por");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      run_xfer("save_5a", 1, 0, 1);
      for (int a = 0; a < 256; a++) begin
         buf_mem[a] = 8'(a + 3);
         map_reg[a] = 8'($urandom);
      end
      run_xfer("load_p3", 0, 0, 1);
      for (int a = 0; a < 256; a++) map_reg[a] = 8'($urandom);
      run_xfer("save_wait7", 1, 0, 6);
      for (int a = 0; a < 256; a++) buf_mem[a] = 8'($urandom);
      run_xfer("load_rand", 0, 0, int'($urandom_range(1, 4)));
      for (int a = 0; a < 256; a++) map_reg[a] = 8'($urandom);
      run_xfer("both_start", 1, 1, 2);

      // Abort in the middle of a write strobe.
      mem_lat = 1;
      clr_counters();
      start_pulse(0, 1);
      wait_for("abort_lwe", 8'd40, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_lwe_we", ss_we, 0);
      chk("abort_lwe_act", ss_act, 0);
      chk("abort_lwe_err", err, 1);
      chk("abort_lwe_busy", busy, 0);
      chk("abort_lwe_req", mem_req, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_lwe_no_done", done_cnt, 0);
      chk("abort_lwe_err_sticky", err, 1);
      for (int a = 0; a < 256; a++) map_reg[a] = 8'($urandom);
      run_xfer("save_after_abort", 1, 0, int'($urandom_range(1, 3)));

      // Abort landing in the same cycle as the buffer ack.
      mem_lat = 1;
      clr_counters();
      start_pulse(1, 0);
      wait_for("abort_ack", 8'd20, 0);
      @(posedge clk); #2;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_ack_busy", busy, 0);
      chk("abort_ack_req", mem_req, 0);
      chk("abort_ack_err", err, 1);
      chk("abort_ack_act", ss_act, 0);
      chk("abort_ack_addr", ss_addr, 8'd20);

      // Asynchronous reset mid-save.
      for (int a = 0; a < 256; a++) buf_mem[a] = 8'($urandom);
      run_xfer("load_before_rst", 0, 0, 1);
      start_pulse(1, 0);
      wait_for("rst_mid", 8'd10, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_rst("rst_mid");
      @(posedge clk); #1;
      rst_n = 1'b1;

`ifdef SS_SUM_EN
      for (int a = 0; a < 256; a++) map_reg[a] = 8'h02;
      run_xfer("sum_wrap", 1, 0, 1);
      chk("sum_wrap_value", ss_sum, 8'h00);
      for (int a = 0; a < 256; a++) map_reg[a] = (a == 0) ? 8'h07 : 8'h00;
      run_xfer("sum_one", 1, 0, 1);
      chk("sum_one_value", ss_sum, 8'h07);
`endif

      // SS_LEN=256 instance: must finish at address 255 without wrapping.
      b_wrap = 0; b_max = 0;
      @(posedge clk); #1;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      cyc = 1; to = 0;
      while (!b_done) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc > 5000) begin to = 1; break; end
      end
      chk("b256_timeout", to, 0);
      chk("b256_cycles", cyc, 256 * (1 + 2 + 1) + 2);
      chk("b256_last_addr", b_addr, 8'd255);
      chk("b256_max_addr", b_max, 255);
      chk("b256_wrap", b_wrap, 0);
      bad = 0;
      for (int a = 0; a < 256; a++) if (b_buf[a] !== (8'(a) ^ 8'hC3)) bad++;
      chk("b256_data_bad", bad, 0);
      @(posedge clk); #1;
      chk("b256_act_end", b_act, 0);
      chk("b256_busy_end", b_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
`default_nettype wire
